sonar_frame_tx: RTL and testbench

- Sits between the echo pulse measurement stage and the CoreUART transmit side.
- Captures each completed measurement (16-bit echo time plus 4-bit servo angle) into a small FIFO.
- Wraps each measurement in a 5-byte checksummed frame and writes the frame byte-by-byte to the UART using the TXRDY/WEN handshake.
- Decouples scan rate from UART throughput; measurements that arrive with the FIFO full are dropped and flagged.

---
 rtl/sonar_frame_tx.sv | 147 ++++++++++++++
 tb/tb_sonar_frame_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/sonar_frame_tx.sv
// Buffers echo measurements in a small FIFO and sends each one to the UART as
// a 5-byte checksummed frame: SYNC, angle, time hi, time lo, sum of bytes 1..3.
module sonar_frame_tx #(
  parameter int          DEPTH     = 4,
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          GAP_CYC   = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_new_ready,
  input  logic [15:0]              i_time1,
  input  logic [3:0]               i_angle,
  input  logic                     i_txrdy,
  output logic                     o_wen,
  output logic [7:0]               o_data_out,
  output logic                     o_drop,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fifo_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int GW = $clog2(GAP_CYC + 1);

  typedef enum logic [2:0] {IDLE, LOAD, WAIT_RDY, WRITE, GAP} state_t;

  state_t          r_state;
  logic [19:0]     r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            r_drop;
  logic [19:0]     r_frame;
  logic [7:0]      r_csum;
  logic [2:0]      r_idx;
  logic [GW-1:0]   r_gap;
  logic            r_wen;
  logic [7:0]      r_data;
  logic            r_busy;

  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic [7:0]      w_byte;

  assign w_full  = (r_count == CW'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_pop   = (r_state == IDLE) && !w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_push  = i_new_ready && (!w_full || w_pop);

  always_comb begin
    w_byte = SYNC_BYTE;
    case (r_idx)
      3'd0:    w_byte = SYNC_BYTE;
      3'd1:    w_byte = {4'h0, r_frame[19:16]};
      3'd2:    w_byte = r_frame[15:8];
      3'd3:    w_byte = r_frame[7:0];
      default: w_byte = r_csum;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_angle, i_time1};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      r_drop <= i_new_ready && w_full && !w_pop;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_wen   <= 1'b1;
      r_data  <= 8'h00;
      r_busy  <= 1'b0;
      r_frame <= '0;
      r_csum  <= 8'h00;
      r_idx   <= '0;
      r_gap   <= '0;
    end else begin
      r_wen <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_pop) begin
            r_frame <= r_mem[r_rd_ptr];
            r_idx   <= 3'd0;
            r_busy  <= 1'b1;
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_csum  <= {4'h0, r_frame[19:16]} + r_frame[15:8] + r_frame[7:0];
          r_state <= WAIT_RDY;
        end
        WAIT_RDY: begin
          if (i_txrdy) begin
            r_wen   <= 1'b0;
            r_data  <= w_byte;
            r_state <= WRITE;
          end
        end
        WRITE: begin
          r_gap   <= GW'(GAP_CYC);
          r_state <= GAP;
        end
        GAP: begin
          // The UART's TXRDY lags the write, so it is not trusted until the gap ends.
          if (r_gap <= GW'(1)) begin
            if (r_idx == 3'd4) begin
              r_busy  <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_idx   <= r_idx + 3'd1;
              r_state <= WAIT_RDY;
            end
          end else begin
            r_gap <= r_gap - GW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_wen        = r_wen;
  assign o_data_out   = r_data;
  assign o_drop       = r_drop;
  assign o_busy       = r_busy;
  assign o_fifo_count = r_count;

endmodule

// File: tb/tb_sonar_frame_tx.sv
// Scoreboard bench for sonar_frame_tx: expected frame bytes are queued when a
// measurement is driven and consumed on every observed wen strobe.
module tb_sonar_frame_tx;

  localparam int         DEPTH     = 4;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         GAP_CYC   = 2;

  logic        clk;
  logic        rst_n;
  logic        new_ready;
  logic [15:0] time1;
  logic [3:0]  angle;
  logic        txrdy;
  logic        wen;
  logic [7:0]  data_out;
  logic        drop;
  logic        busy;
  logic [2:0]  fifo_count;

  logic [7:0]  exp_q[$];
  int          strobe_at[$];
  int          nc = 0;
  int          checks = 0;
  int          errors = 0;
  int          n0;

  sonar_frame_tx #(.DEPTH(DEPTH), .SYNC_BYTE(SYNC_BYTE), .GAP_CYC(GAP_CYC)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_new_ready(new_ready), .i_time1(time1),
    .i_angle(angle), .i_txrdy(txrdy), .o_wen(wen), .o_data_out(data_out),
    .o_drop(drop), .o_busy(busy), .o_fifo_count(fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor: every wen-low cycle must carry the next expected byte.
  always @(negedge clk) begin
    nc++;
    if (wen === 1'b0) begin
      strobe_at.push_back(nc);
      if (exp_q.size() == 0) chk("unexpected_wen", wen, 1);
      else                   chk("byte", data_out, exp_q.pop_front());
    end
  end

  task automatic nstep;
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] t, input logic [3:0] a, input bit accept);
    logic [7:0] b1, b2, b3;
    new_ready = 1'b1;
    time1     = t;
    angle     = a;
    if (accept) begin
      b1 = {4'h0, a};
      b2 = t[15:8];
      b3 = t[7:0];
      exp_q.push_back(SYNC_BYTE);
      exp_q.push_back(b1);
      exp_q.push_back(b2);
      exp_q.push_back(b3);
      exp_q.push_back(8'(b1 + b2 + b3));
    end
    nstep;
    chk("drop", drop, !accept);
    new_ready = 1'b0;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    nstep;
    nstep;
    chk("rst_wen", wen, 1);
    chk("rst_data", data_out, 0);
    chk("rst_drop", drop, 0);
    chk("rst_busy", busy, 0);
    chk("rst_count", fifo_count, 0);
    exp_q.delete();
    strobe_at.delete();
    rst_n = 1'b1;
    nstep;
  endtask

  task automatic wait_strobes(input int n, input int budget);
    int k = 0;
    while (strobe_at.size() < n && k < budget) begin
      nstep;
      k++;
    end
    if (strobe_at.size() < n) chk("strobe_timeout", strobe_at.size(), n);
  endtask

  task automatic drain(input string tag, input int budget);
    int k = 0;
    while ((exp_q.size() != 0 || busy || fifo_count != 0) && k < budget) begin
      nstep;
      k++;
    end
    chk({tag, "_left"}, exp_q.size(), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_count"}, fifo_count, 0);
  endtask

  initial begin
    rst_n = 1'b0; new_ready = 1'b0; time1 = '0; angle = '0; txrdy = 1'b0;

    // Single measurement: bytes, first-strobe latency, byte spacing.
    do_reset;
    txrdy = 1'b1;
    n0 = nc;
    push(16'h1234, 4'h3, 1);
    drain("t1", 200);
    chk("t1_nstrobes", strobe_at.size(), 5);
    if (strobe_at.size() == 5) begin
      chk("t1_latency", strobe_at[0] - n0, 4);
      for (int i = 1; i < 5; i++)
        chk("t1_spacing", strobe_at[i] - strobe_at[i-1], GAP_CYC + 2);
    end

    // Backpressure after B1.
    do_reset;
    txrdy = 1'b1;
    push(16'h1234, 4'h3, 1);
    wait_strobes(2, 50);
    txrdy = 1'b0;
    repeat (50) nstep;
    chk("t2_stall", strobe_at.size(), 2);
    chk("t2_busy", busy, 1);
    txrdy = 1'b1;
    drain("t2", 200);
    chk("t2_nstrobes", strobe_at.size(), 5);

    // Overflow: the first entry moves straight into the frame register, so
    // four more fit before the FIFO is full and only the sixth is dropped.
    do_reset;
    txrdy = 1'b0;
    for (int i = 1; i <= 5; i++) push(16'(i), 4'h0, 1);
    push(16'd6, 4'h0, 0);
    chk("t3_count", fifo_count, 4);
    nstep;
    chk("t3_drop_clr", drop, 0);
    txrdy = 1'b1;
    drain("t3", 600);
    chk("t3_nstrobes", strobe_at.size(), 25);

    // Push while full in the same cycle IDLE pops.
    do_reset;
    txrdy = 1'b0;
    push(16'h0A0A, 4'h1, 1);
    push(16'h0B0B, 4'h2, 1);
    push(16'h0C0C, 4'h3, 1);
    push(16'h0D0D, 4'h4, 1);
    push(16'h0E0E, 4'h5, 1);
    chk("t4_full", fifo_count, 4);
    txrdy = 1'b1;
    begin
      int k = 0;
      while (busy && k < 100) begin nstep; k++; end
    end
    chk("t4_idle", busy, 0);
    push(16'h0F0F, 4'h6, 1);
    chk("t4_count", fifo_count, 4);
    drain("t4", 600);
    chk("t4_nstrobes", strobe_at.size(), 30);

    // Reset mid-frame right after B2.
    do_reset;
    txrdy = 1'b1;
    push(16'h1111, 4'h1, 1);
    push(16'h2222, 4'h2, 1);
    push(16'h3333, 4'h3, 1);
    chk("t5_queued", fifo_count, 2);
    wait_strobes(3, 100);
    rst_n = 1'b0;
    exp_q.delete();
    nstep;
    chk("t5_wen", wen, 1);
    chk("t5_count", fifo_count, 0);
    chk("t5_busy", busy, 0);
    rst_n = 1'b1;
    strobe_at.delete();
    repeat (100) nstep;
    chk("t5_no_wen", strobe_at.size(), 0);
    chk("t5_count_after", fifo_count, 0);

    // Checksum wrap.
    do_reset;
    txrdy = 1'b1;
    push(16'hFFFF, 4'hF, 1);
    drain("t6", 200);
    chk("t6_nstrobes", strobe_at.size(), 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
